// File: rtl/mem_stage_ctrl_if.sv
// EX/MEM sequencing bundle: MEM-stage control inputs toward the controller,
// stage enables / bubble controls / status back to the pipeline.
interface mem_stage_ctrl_if;
    logic branchTakeMem;
    logic JumpMem;
    logic MemReadMem;
    logic MemWriteMem;
    logic memDone;
    logic HaltMem;
    logic loadUseHaz;

    logic pcWriteEn;
    logic ifidWriteEn;
    logic idexWriteEn;
    logic exmemWriteEn;
    logic flushIfId;
    logic controlZeroIdEx;
    logic controlZeroExMem;
    logic redirect;
    logic halted;
    logic memErr;

    modport master (
        output branchTakeMem, JumpMem, MemReadMem, MemWriteMem, memDone, HaltMem, loadUseHaz,
        input  pcWriteEn, ifidWriteEn, idexWriteEn, exmemWriteEn,
        input  flushIfId, controlZeroIdEx, controlZeroExMem, redirect, halted, memErr
    );

    modport slave (
        input  branchTakeMem, JumpMem, MemReadMem, MemWriteMem, memDone, HaltMem, loadUseHaz,
        output pcWriteEn, ifidWriteEn, idexWriteEn, exmemWriteEn,
        output flushIfId, controlZeroIdEx, controlZeroExMem, redirect, halted, memErr
    );
endinterface

// File: rtl/mem_stage_ctrl.sv
// EX/MEM pipeline sequencing controller: stalls, squashes, multi-cycle memory
// waits with timeout, sticky halt/error. Optional stall counter: MEM_STALL_CNT_EN.
module mem_stage_ctrl #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    mem_stage_ctrl_if.slave bus
`ifdef MEM_STALL_CNT_EN
    ,
    output logic [15:0] stallCnt
`endif
);
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {RUN, MEM_WAIT, HALT, ERR} stateType;

    stateType   state, nextState;
    logic [7:0] waitCnt, waitCntNext;
    logic       evalHazards;
    logic       haltedReg, memErrReg;

    // State, wait counter and sticky status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            waitCnt   <= 8'd0;
            haltedReg <= 1'b0;
            memErrReg <= 1'b0;
        end else begin
            state     <= nextState;
            waitCnt   <= waitCntNext;
            haltedReg <= haltedReg | (nextState == HALT) | (nextState == ERR);
            memErrReg <= memErrReg | (nextState == ERR);
        end
    end

    assign bus.halted = haltedReg;
    assign bus.memErr = memErrReg;

    // Next state and same-cycle pipeline controls; outputs held at defaults while in reset
    always_comb begin
        nextState            = state;
        waitCntNext          = waitCnt;
        evalHazards          = 1'b0;
        bus.pcWriteEn        = 1'b1;
        bus.ifidWriteEn      = 1'b1;
        bus.idexWriteEn      = 1'b1;
        bus.exmemWriteEn     = 1'b1;
        bus.flushIfId        = 1'b0;
        bus.controlZeroIdEx  = 1'b0;
        bus.controlZeroExMem = 1'b0;
        bus.redirect         = 1'b0;

        if (!rst) begin
            case (state)
                RUN: begin
                    if ((bus.MemReadMem | bus.MemWriteMem) & ~bus.memDone) begin
                        bus.pcWriteEn    = 1'b0;
                        bus.ifidWriteEn  = 1'b0;
                        bus.idexWriteEn  = 1'b0;
                        bus.exmemWriteEn = 1'b0;
                        nextState        = MEM_WAIT;
                        waitCntNext      = 8'd1;
                    end else begin
                        evalHazards = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    if (!bus.memDone) begin
                        bus.pcWriteEn    = 1'b0;
                        bus.ifidWriteEn  = 1'b0;
                        bus.idexWriteEn  = 1'b0;
                        bus.exmemWriteEn = 1'b0;
                        waitCntNext      = waitCnt + 8'd1;
                        if (waitCnt == WAIT_LAST) begin
                            nextState = ERR;
                        end
                    end else begin
                        evalHazards = 1'b1;
                        nextState   = RUN;
                        waitCntNext = 8'd0;
                    end
                end
                HALT, ERR: begin
                    bus.pcWriteEn    = 1'b0;
                    bus.ifidWriteEn  = 1'b0;
                    bus.idexWriteEn  = 1'b0;
                    bus.exmemWriteEn = 1'b0;
                end
                default: nextState = RUN;
            endcase

            // Halt lets itself drain to WB while squashing everything younger
            if (evalHazards) begin
                if (bus.HaltMem) begin
                    bus.pcWriteEn        = 1'b0;
                    bus.flushIfId        = 1'b1;
                    bus.controlZeroIdEx  = 1'b1;
                    bus.controlZeroExMem = 1'b1;
                    nextState            = HALT;
                end else if (bus.branchTakeMem | bus.JumpMem) begin
                    bus.redirect         = 1'b1;
                    bus.flushIfId        = 1'b1;
                    bus.controlZeroIdEx  = 1'b1;
                    bus.controlZeroExMem = 1'b1;
                end else if (bus.loadUseHaz) begin
                    bus.pcWriteEn       = 1'b0;
                    bus.ifidWriteEn     = 1'b0;
                    bus.controlZeroIdEx = 1'b1;
                end
            end
        end
    end

`ifdef MEM_STALL_CNT_EN
    // Counts front-end stall cycles while the pipeline is live, saturating
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stallCnt <= 16'd0;
        end else if (((state == RUN) || (state == MEM_WAIT)) && !bus.pcWriteEn
                     && (stallCnt != 16'hFFFF)) begin
            stallCnt <= stallCnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: per-cycle expected controls go through
// a scoreboard queue and are compared mid-cycle against the DUT.
module tb_mem_stage_ctrl;
    localparam int TIMEOUT = 4;

    // Input vector order: {branchTakeMem, JumpMem, MemReadMem, MemWriteMem, memDone, HaltMem, loadUseHaz}
    localparam logic [6:0] IN_IDLE     = 7'b0000000;
    localparam logic [6:0] IN_BR       = 7'b1000000;
    localparam logic [6:0] IN_BR_LU    = 7'b1000001;
    localparam logic [6:0] IN_JMP      = 7'b0100000;
    localparam logic [6:0] IN_LU       = 7'b0000001;
    localparam logic [6:0] IN_RD       = 7'b0010000;
    localparam logic [6:0] IN_RD_DONE  = 7'b0010100;
    localparam logic [6:0] IN_RD_BR    = 7'b1010000;
    localparam logic [6:0] IN_RD_BR_DN = 7'b1010100;
    localparam logic [6:0] IN_RD_DN_LU = 7'b0010101;
    localparam logic [6:0] IN_WR       = 7'b0001000;
    localparam logic [6:0] IN_WR_DN_JP = 7'b0101100;
    localparam logic [6:0] IN_HALT     = 7'b0000010;

    // Output vector order: {pcWE, ifidWE, idexWE, exmemWE, flushIfId, zeroIdEx, zeroExMem, redirect, halted, memErr}
    localparam logic [9:0] OUT_DEF    = 10'b1111_0000_00;
    localparam logic [9:0] OUT_STALL  = 10'b0000_0000_00;
    localparam logic [9:0] OUT_REDIR  = 10'b1111_1111_00;
    localparam logic [9:0] OUT_LU     = 10'b0011_0100_00;
    localparam logic [9:0] OUT_HALTIN = 10'b0111_1110_00;
    localparam logic [9:0] OUT_HALTED = 10'b0000_0000_10;
    localparam logic [9:0] OUT_ERR    = 10'b0000_0000_11;

    typedef struct {
        string      tag;
        logic [9:0] outs;
    } expType;

    logic clk;
    logic rst;
    mem_stage_ctrl_if bus();
`ifdef MEM_STALL_CNT_EN
    logic [15:0] stallCnt;
`endif

    expType expQ[$];
    int     checkCount;
    int     passCount;
    int     expStall;

    mem_stage_ctrl #(.MEM_TIMEOUT(TIMEOUT)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
`ifdef MEM_STALL_CNT_EN
        ,
        .stallCnt(stallCnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [9:0] dutOuts();
        return {bus.pcWriteEn, bus.ifidWriteEn, bus.idexWriteEn, bus.exmemWriteEn,
                bus.flushIfId, bus.controlZeroIdEx, bus.controlZeroExMem, bus.redirect,
                bus.halted, bus.memErr};
    endfunction

    task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
        checkCount++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got %b, expected %b at %0t", tag, actual, expected, $time);
        end else begin
            passCount++;
        end
    endtask

    task automatic driveInputs(input logic [6:0] stim);
        {bus.branchTakeMem, bus.JumpMem, bus.MemReadMem, bus.MemWriteMem,
         bus.memDone, bus.HaltMem, bus.loadUseHaz} = stim;
    endtask

    // One clock cycle: drive just after the edge, compare at the falling edge
    task automatic applyStimulus(input string tag, input logic [6:0] stim, input logic [9:0] expOut);
        expType e;
        @(posedge clk);
        #1;
        driveInputs(stim);
        expQ.push_back('{tag, expOut});
        @(negedge clk);
        e = expQ.pop_front();
        checkOutput(e.tag, {6'd0, dutOuts()}, {6'd0, e.outs});
`ifdef MEM_STALL_CNT_EN
        checkOutput({e.tag, ".stallCnt"}, stallCnt, 16'(expStall));
`endif
        if (!e.outs[9] && !e.outs[1]) begin
            expStall++;
        end
    endtask

    // Asserts reset in the middle of a cycle and checks the asynchronous effect
    task automatic resetPulse(input string tag);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checkOutput(tag, {6'd0, dutOuts()}, {6'd0, OUT_DEF});
        driveInputs(IN_IDLE);
        expStall = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        checkCount = 0;
        passCount  = 0;
        expStall   = 0;
        rst        = 1'b1;
        driveInputs(IN_IDLE);
        #3;
        checkOutput("reset", {6'd0, dutOuts()}, {6'd0, OUT_DEF});
        driveInputs(IN_HALT | IN_LU);
        #1;
        checkOutput("resetGate", {6'd0, dutOuts()}, {6'd0, OUT_DEF});
        driveInputs(IN_IDLE);
        @(negedge clk);
        rst = 1'b0;

        applyStimulus("idle",       IN_IDLE,  OUT_DEF);
        applyStimulus("branchLu",   IN_BR_LU, OUT_REDIR);
        applyStimulus("afterBr",    IN_IDLE,  OUT_DEF);
        applyStimulus("jump",       IN_JMP,   OUT_REDIR);
        applyStimulus("loadUse",    IN_LU,    OUT_LU);
        applyStimulus("afterLu",    IN_IDLE,  OUT_DEF);
        applyStimulus("singleMem",  IN_RD_DONE, OUT_DEF);

        applyStimulus("load4.c1",   IN_RD,      OUT_STALL);
        applyStimulus("load4.c2",   IN_RD,      OUT_STALL);
        applyStimulus("load4.c3",   IN_RD,      OUT_STALL);
        applyStimulus("load4.c4",   IN_RD_DONE, OUT_DEF);
        applyStimulus("load4.post", IN_IDLE,    OUT_DEF);

        applyStimulus("memOverBr",  IN_RD_BR,    OUT_STALL);
        applyStimulus("waitDoneBr", IN_RD_BR_DN, OUT_REDIR);
        applyStimulus("wr.c1",      IN_WR,       OUT_STALL);
        applyStimulus("waitDoneJp", IN_WR_DN_JP, OUT_REDIR);
        applyStimulus("rd.c1",      IN_RD,       OUT_STALL);
        applyStimulus("waitDoneLu", IN_RD_DN_LU, OUT_LU);
        applyStimulus("backToRun",  IN_IDLE,     OUT_DEF);

        for (int i = 1; i <= TIMEOUT; i++) begin
            applyStimulus($sformatf("timeout.c%0d", i), IN_WR, OUT_STALL);
        end
        applyStimulus("errEntered", IN_WR, OUT_ERR);
        applyStimulus("errSticky",  IN_BR, OUT_ERR);
        resetPulse("resetInErr");
        applyStimulus("afterErrRst", IN_IDLE, OUT_DEF);

        applyStimulus("haltIn",     IN_HALT, OUT_HALTIN);
        applyStimulus("haltedBr",   IN_BR,   OUT_HALTED);
        applyStimulus("haltedStay", IN_JMP,  OUT_HALTED);
        resetPulse("resetInHalt");
        applyStimulus("afterHaltRst", IN_BR, OUT_REDIR);

        applyStimulus("rdMid.c1",   IN_RD, OUT_STALL);
        resetPulse("resetInWait");
        applyStimulus("afterWaitRst", IN_IDLE, OUT_DEF);
        applyStimulus("memAfterRst",  IN_RD,   OUT_STALL);
        applyStimulus("memAfterRst2", IN_RD_DONE, OUT_DEF);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Pipeline sequencing controller for the EX/MEM boundary of the 5-stage processor. It consumes control state resolved in the MEM stage, namely branch/jump redirects, memory access and completion, and halt. From these it generates the per-stage write enables, bubble/zero controls (including the EX/MEM register's `controlZeroExMem`) and the PC redirect select. It also sequences multi-cycle data-memory accesses with a timeout and enters a sticky halted state.

## Interface
- `MEM_TIMEOUT`, default 16: maximum cycles spent in MEM_WAIT before error; legal range 2–255.
- `clk`  in  1  clock, all state updates on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `branchTakeMem`  in  1  taken branch resolved, instruction in MEM
- `JumpMem`  in  1  jump in MEM
- `MemReadMem`, `MemWriteMem`  in  1 each  memory op in MEM
- `memDone`  in  1  data memory completes this cycle
- `HaltMem`  in  1  halt instruction in MEM
- `loadUseHaz`  in  1  load-use hazard detected in ID
- `pcWriteEn`, `ifidWriteEn`, `idexWriteEn`, `exmemWriteEn`  out  1 each  stage register enables
- `flushIfId`  out  1  zero IF/ID instruction
- `controlZeroIdEx`, `controlZeroExMem`  out  1 each  bubble insertion into ID/EX, EX/MEM
- `redirect`  out  1  PC mux selects branch/jump target
- `halted`  out  1  registered, sticky
- `memErr`  out  1  registered, sticky timeout error

## Operation
- States: RUN, MEM_WAIT, HALT, ERR. Reset → RUN; `waitCnt` (8 bit) = 0; `halted` = `memErr` = 0.
- Default outputs (also during reset): all enables 1, all flush/zero/redirect 0.
- Priority in RUN, highest first: memory pending, halt, redirect, load-use.
- RUN, `(MemReadMem|MemWriteMem) & ~memDone`: all four enables 0, no flush; next MEM_WAIT, `waitCnt` ← 1.
- RUN, `HaltMem`: `pcWriteEn` 0, `flushIfId` = `controlZeroIdEx` = `controlZeroExMem` = 1. The halt instruction itself proceeds to WB. Next HALT.
- RUN, `branchTakeMem|JumpMem`: `redirect` 1, `flushIfId` = `controlZeroIdEx` = `controlZeroExMem` = 1, enables 1. This squashes the three younger instructions. `loadUseHaz` is ignored this cycle.
- RUN, `loadUseHaz` only: `pcWriteEn` = `ifidWriteEn` = 0, `controlZeroIdEx` 1.
- MEM_WAIT, `~memDone`:
  - All enables 0 and `waitCnt` increments.
  - When `waitCnt == MEM_TIMEOUT-1`, next state is ERR.
- MEM_WAIT, `memDone`:
  - Enables released.
  - Halt, redirect and load-use are evaluated exactly as in RUN (excluding the memory-pending rule).
  - Next state is RUN, or HALT if `HaltMem`. `waitCnt` ← 0.
- HALT: all enables 0; `halted` 1 from the first HALT cycle; remain until reset.
- ERR: all enables 0; `halted` = `memErr` = 1; remain until reset.
- Every combinational output is a function of state and current inputs only.

## Timing
- Redirect, flush and load-use responses are same-cycle (Mealy).
- `halted` and `memErr` rise one cycle after the triggering edge condition.
- A single-cycle memory (`memDone` in the same cycle as the op) causes zero stall cycles.
- An N-cycle access (`memDone` in cycle N) stalls N-1 cycles.
- Timeout: with `memDone` never asserted, ERR is entered after exactly `MEM_TIMEOUT` stalled cycles.
- `rst` asserted mid-MEM_WAIT or in HALT/ERR returns to RUN asynchronously, clearing `waitCnt`, `halted` and `memErr`.
- Inputs are sampled only while `rst` is low.

## Configuration
- `MEM_STALL_CNT_EN` defined:
  - Adds output `stallCnt` [15:0].
  - Increments once per clock in which `pcWriteEn` = 0 in state RUN or MEM_WAIT.
  - Saturates at 16'hFFFF; reset value 0.
- `MEM_STALL_CNT_EN` undefined: port and counter are absent; behaviour is otherwise identical.

## Test plan
- Reset: `rst`=1 mid-cycle → all enables 1, zeros/redirect 0, `halted`=`memErr`=0 immediately.
- Branch: `branchTakeMem`=1 with `loadUseHaz`=1 for 1 cycle → that cycle `redirect`=1, `flushIfId`=`controlZeroIdEx`=`controlZeroExMem`=1, `pcWriteEn`=1; next cycle defaults.
- Load-use: `loadUseHaz`=1 alone for 1 cycle → `pcWriteEn`=`ifidWriteEn`=0, `controlZeroIdEx`=1, `idexWriteEn`=1.
- Multi-cycle load: `MemReadMem`=1, `memDone` on the 4th cycle → 3 cycles with all enables 0, release on the 4th; `stallCnt`=3 when `MEM_STALL_CNT_EN` is defined.
- Timeout: `MEM_TIMEOUT`=4, `MemWriteMem`=1, `memDone`=0 forever → 4 stalled cycles, then `memErr`=`halted`=1, enables stay 0; `rst` clears.
- Halt: `HaltMem`=1 → same cycle `pcWriteEn`=0 with all three flush/zero outputs 1; next cycle `halted`=1, and it stays set despite later `branchTakeMem`=1.
